// File: rtl/psub_16bit_seq_pkg.sv
// Shared types and constants for the sequential lane-wise subtractor.
// Holds the FSM state enum, lane geometry and saturation values.
package psa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int LANES  = 4;
  localparam int LANE_W = 4;

  localparam logic [LANE_W-1:0] SAT_POS = 4'h7;
  localparam logic [LANE_W-1:0] SAT_NEG = 4'h8;

endpackage

// File: rtl/psub_16bit_seq_sat_sub.sv
// One signed 4-bit lane: d = a - b with overflow flag.
// Ports: a, b in; d, ovfl out. `PSUB_SAT_EN clamps overflowing lanes.
module sat_sub_4bit
  import psa_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] d,
  output logic       ovfl
);

  logic [3:0] raw;

  assign raw  = a - b;
  // Operands of opposite sign whose result sign leaves the minuend's.
  assign ovfl = (a[3] != b[3]) && (raw[3] != a[3]);

`ifdef PSUB_SAT_EN
  assign d = !ovfl ? raw : (a[3] ? SAT_NEG : SAT_POS);
`else
  assign d = raw;
`endif

endmodule

// File: rtl/psub_16bit_seq.sv
// Multi-cycle PSUB: four nibble lanes through one shared lane subtractor.
// Ports: clk, rst, start, A, B in; busy, done, Diff, Ovfl out. Macro: PSUB_SAT_EN.
module psub_16bit_seq
  import psa_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        busy,
  output logic        done,
  output logic [15:0] Diff,
  output logic [3:0]  Ovfl
);

  state_t      state;
  state_t      nstate;
  logic [1:0]  idx;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [15:0] acc;
  logic [3:0]  flg;
  logic [3:0]  la;
  logic [3:0]  lb;
  logic [3:0]  ld;
  logic        lo;
  logic        last;

  assign la   = a_q[{idx, 2'b00} +: 4];
  assign lb   = b_q[{idx, 2'b00} +: 4];
  assign last = (idx == 2'd3);
  assign busy = (state == CALC);

  sat_sub_4bit u_lane (
    .a    (la),
    .b    (lb),
    .d    (ld),
    .ovfl (lo)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (start) nstate = CALC;
      CALC:    if (last) nstate = DONE;
      DONE:    nstate = start ? CALC : IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Outputs load on the final lane edge so they are valid
  // throughout the DONE cycle, merging in the lane just computed.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx  <= 2'd0;
      a_q  <= 16'h0;
      b_q  <= 16'h0;
      acc  <= 16'h0;
      flg  <= 4'h0;
      done <= 1'b0;
      Diff <= 16'h0;
      Ovfl <= 4'h0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q <= A;
            b_q <= B;
            idx <= 2'd0;
            acc <= 16'h0;
            flg <= 4'h0;
          end
        end
        CALC: begin
          acc[{idx, 2'b00} +: 4] <= ld;
          flg[idx]               <= lo;
          idx                    <= idx + 2'd1;
          if (last) begin
            Diff <= {ld, acc[11:0]};
            Ovfl <= {lo, flg[2:0]};
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_psub_16bit_seq.sv
// Directed bench for psub_16bit_seq with an expected-result queue.
// Checks handshake timing, lane results, hold, abort on reset.
module tb_psub_16bit_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic [15:0] Diff;
  logic [3:0]  Ovfl;

  int n_cmp = 0;
  int n_bad = 0;
  logic [19:0] sbq[$];
  logic [19:0] prev;

  always #5 clk = ~clk;

  psub_16bit_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Diff  (Diff),
    .Ovfl  (Ovfl)
  );

  function automatic logic [19:0] model(
    input logic [15:0] a,
    input logic [15:0] b
  );
    logic [15:0] d;
    logic [3:0]  f;
    logic [3:0]  ai, bi, di;
    d = '0;
    f = '0;
    for (int i = 0; i < 4; i++) begin
      ai = a[4*i +: 4];
      bi = b[4*i +: 4];
      di = ai - bi;
      f[i] = (ai[3] != bi[3]) && (di[3] != ai[3]);
`ifdef PSUB_SAT_EN
      if (f[i]) di = ai[3] ? 4'h8 : 4'h7;
`endif
      d[4*i +: 4] = di;
    end
    return {d, f};
  endfunction

  task automatic chk(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(
    input logic [15:0] a,
    input logic [15:0] b
  );
    A = a;
    B = b;
    start = 1'b1;
    sbq.push_back(model(a, b));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Four CALC cycles; poke>0 pulses start with junk operands then.
  task automatic run_calc(input int poke);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("busy c%0d", k), busy, 1);
      chk($sformatf("done c%0d", k), done, 0);
      chk($sformatf("hold c%0d", k), {Diff, Ovfl}, prev);
      if (k == poke) begin
        start = 1'b1;
        A = 16'h5A5A;
        B = 16'hA5A5;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic finish_done(input string tag);
    logic [19:0] e;
    @(negedge clk);
    chk({tag, " done"}, done, 1);
    chk({tag, " busy"}, busy, 0);
    if (sbq.size() == 0) begin
      chk({tag, " queue"}, 0, 1);
    end else begin
      e = sbq.pop_front();
      chk({tag, " Diff"}, Diff, e[19:4]);
      chk({tag, " Ovfl"}, Ovfl, e[3:0]);
      prev = e;
    end
  endtask

  task automatic to_idle(input string tag);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, " idle done"}, done, 0);
    chk({tag, " idle busy"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    prev = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst Diff", Diff, 0);
    chk("rst Ovfl", Ovfl, 0);

    start_op(16'h1234, 16'h0111);
    run_calc(0);
    finish_done("basic");
    to_idle("basic");

    start_op(16'h7000, 16'h8000);
    run_calc(0);
    finish_done("pos ovf");
    to_idle("pos ovf");

    start_op(16'h8888, 16'h1111);
    run_calc(0);
    finish_done("neg ovf");
    to_idle("neg ovf");

    start_op(16'hFFFF, 16'hFFFF);
    run_calc(0);
    finish_done("ffff");
    to_idle("ffff");

    start_op(16'h3C9E, 16'h6A21);
    run_calc(2);
    finish_done("ignore");
    start_op(16'h0F80, 16'hF07F);
    run_calc(0);
    finish_done("b2b");
    to_idle("b2b");

    start_op(16'h4321, 16'h1234);
    @(posedge clk); #1;
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort Diff", Diff, 0);
    chk("abort Ovfl", Ovfl, 0);
    void'(sbq.pop_front());
    prev = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("no done %0d", k), done, 0);
    end

    start_op(16'h2468, 16'h1357);
    run_calc(0);
    finish_done("recover");
    to_idle("recover");

    chk("queue empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
